// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: CRC32 constants and the
// FCS sequencer state encoding.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PAD     = 2'd2,
    FCS     = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr.sv
// Combinational Galois LFSR step: advances state_in by
// DATA_WIDTH bits of data_in in one cycle.
module lfsr #(
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04c11db7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(
    input logic [LFSR_WIDTH-1:0] v
  );
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) begin
      r[i] = v[LFSR_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] RPOLY = reflect(LFSR_POLY);

  // Reflected mode shifts right and consumes data LSB first.
  always_comb begin
    logic [LFSR_WIDTH-1:0] s;
    logic                  fb;
    s  = state_in;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE) begin
        fb = s[0] ^ data_in[i];
        s  = {1'b0, s[LFSR_WIDTH-1:1]};
        if (fb) s = s ^ RPOLY;
      end else begin
        fb = s[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        s  = {s[LFSR_WIDTH-2:0], 1'b0};
        if (fb) s = s ^ LFSR_POLY;
      end
    end
    state_out = s;
  end

endmodule

// File: rtl/eth_fcs_insert.sv
// Ethernet TX FCS sequencer: forwards payload, zero-pads to
// the minimum length and appends the inverted CRC32.
module eth_fcs_insert
  import eth_pkg::*;
#(
  parameter bit ENABLE_PADDING   = 1'b1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy
);

  localparam int CNT_W = $clog2(MIN_FRAME_LENGTH);
  localparam logic [CNT_W-1:0] PAD_MAX =
    CNT_W'(MIN_FRAME_LENGTH - 4);

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_crc, w_crc_nxt, w_crc_upd, w_fcs;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]       r_fcs_idx, w_fcs_idx_nxt;
  logic             r_run;
  logic [7:0]       r_tdata, w_tdata, w_fcs_byte;
  logic             r_tvalid, r_tlast, r_tuser;
  logic             w_load, w_tlast, w_tuser;
  logic             w_load_ok, w_in_fire;

  assign w_load_ok = !r_tvalid | m_axis_tready;
  // r_run holds tready low until the first edge after reset.
  assign s_axis_tready = r_run & w_load_ok &
    (r_state == IDLE | r_state == PAYLOAD);
  assign w_in_fire = s_axis_tvalid & s_axis_tready;
  assign w_cnt_inc = (r_cnt == PAD_MAX) ? r_cnt
                                        : r_cnt + CNT_W'(1);
  assign w_fcs = ~r_crc;

  always_comb begin
    unique case (r_fcs_idx)
      2'd0: w_fcs_byte = w_fcs[7:0];
      2'd1: w_fcs_byte = w_fcs[15:8];
      2'd2: w_fcs_byte = w_fcs[23:16];
      2'd3: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  assign w_tdata = (r_state == PAD) ? 8'h00 :
                   (r_state == FCS) ? w_fcs_byte :
                   s_axis_tdata;

  lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC32_POLY),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_lfsr (
    .data_in   (w_tdata),
    .state_in  (r_crc),
    .state_out (w_crc_upd)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_crc_nxt     = r_crc;
    w_cnt_nxt     = r_cnt;
    w_fcs_idx_nxt = r_fcs_idx;
    w_load        = 1'b0;
    w_tlast       = 1'b0;
    w_tuser       = 1'b0;
    unique case (r_state)
      IDLE, PAYLOAD: begin
        if (w_in_fire) begin
          w_load = 1'b1;
          if (!s_axis_tlast) begin
            w_state_nxt = PAYLOAD;
            w_crc_nxt   = w_crc_upd;
            w_cnt_nxt   = w_cnt_inc;
          end else if (s_axis_tuser) begin
            w_tlast     = 1'b1;
            w_tuser     = 1'b1;
            w_crc_nxt   = CRC32_INIT;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_crc_nxt     = w_crc_upd;
            w_cnt_nxt     = w_cnt_inc;
            w_fcs_idx_nxt = 2'd0;
            w_state_nxt   =
              (ENABLE_PADDING && (w_cnt_inc < PAD_MAX))
                ? PAD : FCS;
          end
        end
      end
      PAD: begin
        if (w_load_ok) begin
          w_load    = 1'b1;
          w_crc_nxt = w_crc_upd;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == PAD_MAX) begin
            w_state_nxt   = FCS;
            w_fcs_idx_nxt = 2'd0;
          end
        end
      end
      FCS: begin
        if (w_load_ok) begin
          w_load        = 1'b1;
          w_tlast       = (r_fcs_idx == 2'd3);
          w_fcs_idx_nxt = r_fcs_idx + 2'd1;
          if (r_fcs_idx == 2'd3) begin
            w_crc_nxt   = CRC32_INIT;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_crc     <= CRC32_INIT;
      r_cnt     <= '0;
      r_fcs_idx <= 2'd0;
      r_run     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_crc     <= w_crc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fcs_idx <= w_fcs_idx_nxt;
      r_run     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 8'h00;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_tdata;
      r_tlast  <= w_tlast;
      r_tuser  <= w_tuser;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign busy          = (r_state != IDLE);

endmodule

// File: doc/eth_fcs_insert.md
Name: eth_fcs_insert

Overview:
- Transmit-side Ethernet FCS sequencer: takes an 8-bit AXI-stream frame, optionally zero-pads it to the minimum length, computes CRC32 and appends the 4-byte FCS.
- Owns the CRC state register and sequences the shared combinational `lfsr` datapath: initialise per frame, update per accepted byte, finalise/invert, emit.
- Sits between the MAC TX framing logic and the GMII/RGMII transmit stage.

Parameters:
- ENABLE_PADDING, 1, 1 = zero-pad payload to MIN_FRAME_LENGTH-4 bytes before the FCS.
- MIN_FRAME_LENGTH, 64, minimum frame length on the wire including FCS, in bytes; legal range 5..1024.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  payload byte
- s_axis_tvalid  input  1  input beat valid
- s_axis_tready  output  1  input beat accepted when tvalid & tready
- s_axis_tlast  input  1  last payload byte
- s_axis_tuser  input  1  frame error, sampled with tlast
- m_axis_tdata  output  8  output byte, registered
- m_axis_tvalid  output  1  output beat valid, registered
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last byte of frame (final FCS byte, or error-terminated byte)
- m_axis_tuser  output  1  error flag on the last beat
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; crc=32'hFFFFFFFF; byte counter=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0; m_axis_tuser=0; s_axis_tready=0; busy=0.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is dropped with no tlast emitted; upstream re-sends.
- Output stage: a single register. It may load when (!m_axis_tvalid | m_axis_tready), written `load_ok`. m_axis_tvalid clears when m_axis_tready=1 and nothing new loads.
- s_axis_tready = load_ok & (state==IDLE | state==PAYLOAD). Combinational from m_axis_tready; no other input path.
- CRC datapath: sub-module `lfsr` instance. Configuration: Galois, 32 bits, polynomial 32'h04c11db7, REVERSE=1, DATA_WIDTH=8, data_in=byte, state_in=crc.
- CRC update: crc <= lfsr state_out on every byte loaded into the output register, whether payload or pad.
- FCS value: ~crc. Emitted least-significant byte first: bits [7:0], then [15:8], [23:16], [31:24].
- Byte counter: counts payload+pad bytes and saturates at MIN_FRAME_LENGTH-4.
- States:
  - IDLE: first accepted beat loads as PAYLOAD data with crc starting from 32'hFFFFFFFF, then go to PAYLOAD. A single-beat frame (tlast=1) takes the PAYLOAD-tlast rules below in the same cycle.
  - PAYLOAD, accepted beat with tlast=0: forward the byte with m_axis_tlast=0.
  - PAYLOAD, accepted tlast with tuser=1: forward the byte with m_axis_tlast=1, m_axis_tuser=1. No pad, no FCS. crc<=FFFFFFFF, counter<=0, go to IDLE.
  - PAYLOAD, accepted tlast with tuser=0: forward the byte with tlast=0. Go to PAD if ENABLE_PADDING and counter+1 < MIN_FRAME_LENGTH-4; otherwise go to FCS with fcs_idx=0.
  - PAD: on each load_ok, emit 8'h00 and increment the counter. When the counter reaches MIN_FRAME_LENGTH-4, go to FCS.
  - FCS: on each load_ok, emit FCS byte fcs_idx. m_axis_tlast=1 when fcs_idx=3. After byte 3: crc<=FFFFFFFF, counter<=0, go to IDLE.
- Latency: input byte to m_axis_tvalid is 1 cycle.
- Throughput: 1 byte/cycle under no backpressure. Back-to-back frames carry a (pad+4)-cycle FCS insertion bubble and no extra idle cycle; the next frame's first beat may be accepted in the cycle after the last FCS byte loads.
- Boundaries:
  - A frame of exactly MIN_FRAME_LENGTH-4 bytes gets no pad.
  - Frames longer than that: the counter stays saturated and no pad is added.
  - Input tvalid gaps are legal in PAYLOAD; output holds valid with no change.
  - Output data/last/user must stay stable while m_axis_tvalid & !m_axis_tready.

Decomposition:
- Shared package `eth_pkg` holds:
  - CRC32_POLY = 32'h04c11db7
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hDEBB20E3 (used by the checker)
  - state enum IDLE/PAYLOAD/PAD/FCS
- One sub-module: `lfsr` (existing combinational CRC). No other sub-modules.

Test Plan:
1. ENABLE_PADDING=0, input ASCII "123456789" (31..39), no backpressure -> 13 output bytes: 31..39 then 26 39 F4 CB. tlast only on CB; busy low afterwards.
2. ENABLE_PADDING=1, 1-byte frame 8'hAA -> AA, then 59 bytes of 00, then 4 FCS bytes. 64 beats total; tlast on beat 64; FCS matches a reference CRC32 of the 60 bytes.
3. 60-byte frame of incrementing 00..3B -> no pad bytes, 64 beats, correct FCS. Repeat with 61 bytes -> 65 beats.
4. Random m_axis_tready (50%) on test 1 -> identical byte sequence. Outputs held stable while stalled; no beat duplicated or dropped.
5. 10-byte frame with tuser=1 on tlast -> 10 bytes out, tlast+tuser on byte 10, no pad/FCS. A following good frame has a correct FCS, proving crc was re-initialised.
6. rst_n pulsed low during the PAD state -> m_axis_tvalid=0 and busy=0 asynchronously. The next frame's FCS is correct.
